// File: rtl/captura_pixeles.sv
// captura_pixeles: captures RGB565 byte pairs from a parallel camera port,
// repacks each pixel into the configured output format and writes it into a
// frame-buffer RAM, one frame per VSYNC period.
module captura_pixeles #(
  parameter  int FORMAT  = 0,    // 0 = RGB332, 1 = RGB444, 2 = RGB565
  parameter  int H_PIX   = 160,  // pixels per stored line
  parameter  int V_LINES = 120,  // lines per stored frame
  parameter  int ADDR_W  = 15,   // RAM address width
  localparam int DW      = (FORMAT == 0) ? 8 : (FORMAT == 1) ? 12 : 16
) (
  input  logic              PCLK,
  input  logic              RST_N,
  input  logic              HREF,
  input  logic              VSYNC,
  input  logic [7:0]        D,
  input  logic              EN,
  output logic [DW-1:0]     DP_RAM_data_in,
  output logic [ADDR_W-1:0] DP_RAM_addr_in,
  output logic              DP_RAM_regW,
  output logic              FRAME_DONE,
  output logic              LINE_ERR,
  output logic [7:0]        FRAME_CNT
);

  // Reject unsupported builds at elaboration time.
  if (FORMAT < 0 || FORMAT > 2) begin : g_bad_format
    $error("captura_pixeles: FORMAT must be 0, 1 or 2");
  end
  if (H_PIX * V_LINES > 2 ** ADDR_W) begin : g_bad_size
    $error("captura_pixeles: H_PIX*V_LINES does not fit in ADDR_W address bits");
  end

  localparam int PIX_W  = $clog2(H_PIX + 1);
  localparam int LINE_W = $clog2(V_LINES + 1);
  localparam int BASE_W = ADDR_W + 1;   // line base may reach H_PIX*V_LINES

  localparam logic [PIX_W-1:0]  PIX_MAX   = PIX_W'(H_PIX);
  localparam logic [LINE_W-1:0] LINE_MAX  = LINE_W'(V_LINES);
  localparam logic [BASE_W-1:0] BASE_STEP = BASE_W'(H_PIX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t state, state_next;

  // Registered camera inputs plus one more stage for edge detection.
  logic       href_q, href_qq;
  logic       vsync_q, vsync_qq;
  logic [7:0] d_q;

  logic              phase;    // 0 = expecting byte 0, 1 = expecting byte 1
  logic [7:0]        byte0;    // first byte of the pixel being assembled
  logic [PIX_W-1:0]  pix;      // pixel index within the current line (saturating)
  logic [LINE_W-1:0] line;     // line index within the frame (saturating)
  logic [BASE_W-1:0] base;     // line * H_PIX, kept incrementally

  logic frame_start, frame_stop;
  logic vsync_fall, vsync_rise;
  logic in_cap, byte_hi, line_end, pix_ok, wr_ok;

  logic [15:0]       rgb565;
  logic [DW-1:0]     pix_packed;
  logic [ADDR_W-1:0] wr_addr;
  logic              unused_rgb;

  assign vsync_fall = vsync_qq & ~vsync_q;
  assign vsync_rise = ~vsync_qq & vsync_q;
  assign in_cap     = (state == CAPTURE);
  assign byte_hi    = in_cap & href_q & phase;
  assign line_end   = in_cap & href_qq & ~href_q;
  assign pix_ok     = (pix < PIX_MAX) && (line < LINE_MAX);
  assign wr_ok      = byte_hi & pix_ok;
  assign wr_addr    = ADDR_W'(base + BASE_W'(pix));
  assign rgb565     = {byte0, d_q};
  // Narrow formats drop some colour bits on purpose.
  assign unused_rgb = ^rgb565;

  // Input sampling: every decision below works on these registered copies.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      href_q   <= 1'b0;
      href_qq  <= 1'b0;
      vsync_q  <= 1'b0;
      vsync_qq <= 1'b0;
      d_q      <= 8'd0;
    end else begin
      // NOTE: non-blocking so each stage samples the value from before the edge.
      href_q   <= HREF;
      href_qq  <= href_q;
      vsync_q  <= VSYNC;
      vsync_qq <= vsync_q;
      d_q      <= D;
    end
  end

  // Frame state register.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  // Frame sequencing: arm on blanking, capture from VSYNC fall to VSYNC rise.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next  = state;
    frame_start = 1'b0;
    frame_stop  = 1'b0;
    case (state)
      IDLE: begin
        if (vsync_q) state_next = ARMED;
      end
      ARMED: begin
        if (vsync_fall && EN) begin
          state_next  = CAPTURE;
          frame_start = 1'b1;
        end
      end
      CAPTURE: begin
        if (vsync_rise) begin
          state_next = ARMED;
          frame_stop = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Repack the assembled RGB565 pixel into the output format.
  always_comb begin
    pix_packed = '0;
    case (FORMAT)
      0:       pix_packed = DW'({rgb565[15:13], rgb565[10:8], rgb565[4:3]});
      1:       pix_packed = DW'({rgb565[15:12], rgb565[10:7], rgb565[4:1]});
      default: pix_packed = DW'(rgb565);
    endcase
  end

  // Byte phase, pixel/line position and sticky line-error tracking.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      phase    <= 1'b0;
      byte0    <= 8'd0;
      pix      <= '0;
      line     <= '0;
      base     <= '0;
      LINE_ERR <= 1'b0;
    end else if (frame_start) begin
      phase    <= 1'b0;
      pix      <= '0;
      line     <= '0;
      base     <= '0;
      LINE_ERR <= 1'b0;
    end else if (in_cap) begin
      phase <= href_q ? ~phase : 1'b0;
      if (href_q && !phase) byte0 <= d_q;
      if (byte_hi) begin
        if (pix_ok) pix      <= pix + 1'b1;
        else        LINE_ERR <= 1'b1;
      end
      if (line_end) begin
        // Short line or a dangling first byte both flag an error; the
        // dangling byte is simply forgotten when the phase clears.
        if (pix < PIX_MAX || phase) LINE_ERR <= 1'b1;
        pix <= '0;
        if (line < LINE_MAX) begin
          line <= line + 1'b1;
          base <= base + BASE_STEP;
        end
      end
    end else begin
      phase <= 1'b0;
    end
  end

  // RAM write port and frame completion outputs.
  always_ff @(posedge PCLK or negedge RST_N) begin
    if (!RST_N) begin
      DP_RAM_data_in <= '0;
      DP_RAM_addr_in <= '0;
      DP_RAM_regW    <= 1'b0;
      FRAME_DONE     <= 1'b0;
      FRAME_CNT      <= 8'd0;
    end else begin
      DP_RAM_regW <= wr_ok;
      FRAME_DONE  <= frame_stop;
      if (wr_ok) begin
        DP_RAM_data_in <= pix_packed;
        DP_RAM_addr_in <= wr_addr;
      end
      if (frame_stop) FRAME_CNT <= FRAME_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_captura_pixeles.sv
// tb_captura_pixeles: drives three captura_pixeles instances (RGB332, RGB444,
// RGB565, all H_PIX=4, V_LINES=2) from one camera stream and checks the RAM
// writes, frame pulses and error flag against hand-computed expectations.
module tb_captura_pixeles;

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] e565;
    logic [11:0] e444;
    logic [7:0]  e332;
  } vec_t;

  typedef struct {
    logic [14:0] addr;
    logic [15:0] d565;
    logic [11:0] d444;
    logic [7:0]  d332;
    int          cyc;
  } wr_t;

  logic       pclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       href = 1'b0;
  logic       vsync = 1'b0;
  logic [7:0] d = 8'd0;
  logic       en = 1'b1;

  logic [15:0] data565;
  logic [11:0] data444;
  logic [7:0]  data332;
  logic [14:0] addr565, addr444, addr332;
  logic        regw565, regw444, regw332;
  logic        done565, done444, done332;
  logic        err565, err444, err332;
  logic [7:0]  cnt565, cnt444, cnt332;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   fd_cnt = 0;
  int   lane_diff = 0;
  int   b1_cyc = 0;
  wr_t  wq[$];
  vec_t vt[8];

  captura_pixeles #(.FORMAT(2), .H_PIX(4), .V_LINES(2), .ADDR_W(15)) u565 (
    .PCLK(pclk), .RST_N(rst_n), .HREF(href), .VSYNC(vsync), .D(d), .EN(en),
    .DP_RAM_data_in(data565), .DP_RAM_addr_in(addr565), .DP_RAM_regW(regw565),
    .FRAME_DONE(done565), .LINE_ERR(err565), .FRAME_CNT(cnt565));

  captura_pixeles #(.FORMAT(1), .H_PIX(4), .V_LINES(2), .ADDR_W(15)) u444 (
    .PCLK(pclk), .RST_N(rst_n), .HREF(href), .VSYNC(vsync), .D(d), .EN(en),
    .DP_RAM_data_in(data444), .DP_RAM_addr_in(addr444), .DP_RAM_regW(regw444),
    .FRAME_DONE(done444), .LINE_ERR(err444), .FRAME_CNT(cnt444));

  captura_pixeles #(.FORMAT(0), .H_PIX(4), .V_LINES(2), .ADDR_W(15)) u332 (
    .PCLK(pclk), .RST_N(rst_n), .HREF(href), .VSYNC(vsync), .D(d), .EN(en),
    .DP_RAM_data_in(data332), .DP_RAM_addr_in(addr332), .DP_RAM_regW(regw332),
    .FRAME_DONE(done332), .LINE_ERR(err332), .FRAME_CNT(cnt332));

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Collect writes and frame pulses away from the active edge.
  always @(negedge pclk) begin
    if (regw565) begin
      wr_t w;
      w.addr = addr565;
      w.d565 = data565;
      w.d444 = data444;
      w.d332 = data332;
      w.cyc  = cyc;
      wq.push_back(w);
      if (addr444 !== addr565 || addr332 !== addr565) lane_diff = lane_diff + 1;
    end
    if (done565) fd_cnt = fd_cnt + 1;
    if (regw444 !== regw565 || regw332 !== regw565 ||
        done444 !== done565 || done332 !== done565 ||
        err444 !== err565 || err332 !== err565 ||
        cnt444 !== cnt565 || cnt332 !== cnt565) lane_diff = lane_diff + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    d    = b;
    @(negedge pclk);
  endtask

  task automatic send_px(input logic [7:0] b0, input logic [7:0] b1);
    send_byte(b0);
    b1_cyc = cyc;
    send_byte(b1);
  endtask

  task automatic line_gap();
    href = 1'b0;
    d    = 8'd0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic frame_begin();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (4) @(negedge pclk);
    vsync = 1'b0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic frame_end();
    href  = 1'b0;
    vsync = 1'b1;
    repeat (5) @(negedge pclk);
  endtask

  task automatic send_table_frame();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 4; j++) send_px(vt[i*4+j].b0, vt[i*4+j].b1);
      line_gap();
    end
  endtask

  task automatic check_table_frame(input string tag);
    check({tag, "_nwr"}, wq.size(), 8);
    for (int k = 0; k < wq.size() && k < 8; k++) begin
      check($sformatf("%s_addr%0d", tag, k), wq[k].addr, k);
      check($sformatf("%s_d565_%0d", tag, k), wq[k].d565, vt[k].e565);
      check($sformatf("%s_d444_%0d", tag, k), wq[k].d444, vt[k].e444);
      check($sformatf("%s_d332_%0d", tag, k), wq[k].d332, vt[k].e332);
    end
  endtask

  initial begin
    int lat_ref;

    //         b0     b1     RGB565     RGB444   RGB332
    vt[0] = '{8'hF8, 8'h00, 16'hF800, 12'hF00, 8'hE0};
    vt[1] = '{8'hFF, 8'hE0, 16'hFFE0, 12'hFF0, 8'hFC};
    vt[2] = '{8'h00, 8'h1F, 16'h001F, 12'h00F, 8'h03};
    vt[3] = '{8'h07, 8'hE0, 16'h07E0, 12'h0F0, 8'h1C};
    vt[4] = '{8'hFF, 8'hFF, 16'hFFFF, 12'hFFF, 8'hFF};
    vt[5] = '{8'h00, 8'h00, 16'h0000, 12'h000, 8'h00};
    vt[6] = '{8'h84, 8'h10, 16'h8410, 12'h888, 8'h92};
    vt[7] = '{8'h7B, 8'hEF, 16'h7BEF, 12'h777, 8'h6D};

    // Reset state.
    repeat (3) @(negedge pclk);
    check("rst_regw", regw565, 0);
    check("rst_data", data565, 0);
    check("rst_addr", addr565, 0);
    check("rst_done", done565, 0);
    check("rst_err",  err565, 0);
    check("rst_cnt",  cnt565, 0);
    rst_n = 1'b1;
    @(negedge pclk);

    // Clean 4x2 frame from the vector table; latency and held outputs.
    wq.delete(); fd_cnt = 0;
    frame_begin();
    send_px(vt[0].b0, vt[0].b1);
    lat_ref = b1_cyc;
    for (int j = 1; j < 4; j++) send_px(vt[j].b0, vt[j].b1);
    line_gap();
    for (int j = 4; j < 8; j++) send_px(vt[j].b0, vt[j].b1);
    line_gap();
    frame_end();
    check_table_frame("t1");
    if (wq.size() > 0) check("t1_latency", wq[0].cyc - lat_ref, 2);
    check("t1_done", fd_cnt, 1);
    check("t1_cnt",  cnt565, 1);
    check("t1_err",  err565, 0);
    check("t1_hold_addr", addr565, 7);
    check("t1_hold_data", data565, vt[7].e565);
    check("t1_regw_idle", regw565, 0);

    // Over-long line then short line.
    wq.delete(); fd_cnt = 0;
    frame_begin();
    repeat (6) send_px(8'h07, 8'hE0);
    line_gap();
    repeat (3) send_px(8'h07, 8'hE0);
    line_gap();
    frame_end();
    check("t2_nwr", wq.size(), 7);
    for (int k = 0; k < wq.size() && k < 7; k++) begin
      check($sformatf("t2_addr%0d", k), wq[k].addr, k);
      check($sformatf("t2_data%0d", k), wq[k].d565, 16'h07E0);
    end
    check("t2_err", err565, 1);
    check("t2_cnt", cnt565, 2);

    // VSYNC rises mid-line together with byte 1 of a pixel.
    wq.delete(); fd_cnt = 0;
    frame_begin();
    repeat (4) send_px(8'hF8, 8'h00);
    line_gap();
    send_px(8'h12, 8'h34);
    send_byte(8'h56);
    vsync = 1'b1;
    send_byte(8'h78);
    send_px(8'h9A, 8'hBC);
    frame_end();
    check("t3_nwr", wq.size(), 6);
    if (wq.size() == 6) begin
      check("t3_addr4", wq[4].addr, 4);
      check("t3_data4", wq[4].d565, 16'h1234);
      check("t3_addr5", wq[5].addr, 5);
      check("t3_data5", wq[5].d565, 16'h5678);
    end
    check("t3_done", fd_cnt, 1);
    check("t3_cnt",  cnt565, 3);

    // Dangling odd byte at the end of a line.
    wq.delete(); fd_cnt = 0;
    frame_begin();
    send_byte(8'hF8);
    send_byte(8'h00);
    send_byte(8'hAA);
    line_gap();
    for (int j = 0; j < 4; j++) send_px(vt[j].b0, vt[j].b1);
    line_gap();
    frame_end();
    check("t4_nwr", wq.size(), 5);
    if (wq.size() == 5) begin
      check("t4_addr0", wq[0].addr, 0);
      check("t4_data0", wq[0].d565, 16'hF800);
      for (int k = 1; k < 5; k++) begin
        check($sformatf("t4_addr%0d", k), wq[k].addr, k + 3);
        check($sformatf("t4_data%0d", k), wq[k].d565, vt[k-1].e565);
      end
    end
    check("t4_err", err565, 1);
    check("t4_cnt", cnt565, 4);

    // Capture disabled for one frame, then re-enabled.
    wq.delete(); fd_cnt = 0;
    en = 1'b0;
    frame_begin();
    send_table_frame();
    frame_end();
    check("t5_off_nwr",  wq.size(), 0);
    check("t5_off_done", fd_cnt, 0);
    check("t5_off_cnt",  cnt565, 4);
    check("t5_off_err",  err565, 1);
    en = 1'b1;
    wq.delete(); fd_cnt = 0;
    frame_begin();
    send_table_frame();
    frame_end();
    check_table_frame("t5");
    check("t5_done", fd_cnt, 1);
    check("t5_cnt",  cnt565, 5);
    check("t5_err",  err565, 0);

    // Reset pulsed in the middle of a line.
    frame_begin();
    for (int j = 0; j < 3; j++) send_px(vt[j].b0, vt[j].b1);
    send_byte(vt[3].b0);
    rst_n = 1'b0;
    #1;
    check("t6_rst_regw", regw565, 0);
    check("t6_rst_addr", addr565, 0);
    check("t6_rst_data", data565, 0);
    check("t6_rst_cnt",  cnt565, 0);
    check("t6_rst_err",  err565, 0);
    check("t6_rst_done", done565, 0);
    @(negedge pclk);
    rst_n = 1'b1;
    wq.delete(); fd_cnt = 0;
    send_byte(vt[3].b1);
    repeat (2) send_px(8'hF8, 8'h00);
    line_gap();
    repeat (4) send_px(8'hF8, 8'h00);
    line_gap();
    check("t6_nwr_after_rst", wq.size(), 0);
    frame_begin();
    send_table_frame();
    frame_end();
    check_table_frame("t6");
    check("t6_cnt", cnt565, 1);

    check("lanes_agree", lane_diff, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
